optotype_matrix_scanner: RTL

//  Drives an N x N LED dot matrix for the vision tester with a rotatable optotype glyph.
//  It generates row scan timing from clk1, rotates a parameter-defined glyph by 0/90/180/270 deg,
//  and accepts orientation/blank commands through a valid/ready handshake. Commands are applied

---
 rtl/optotype_matrix_scanner_pkg.sv | 30 +++
 rtl/optotype_matrix_scanner_if.sv | 18 +
 rtl/optotype_matrix_scanner_scan_timebase.sv | 51 +++++
 rtl/optotype_matrix_scanner.sv | 129 ++++++++++++
 4 files changed

// File: rtl/optotype_matrix_scanner_pkg.sv
// optotype_matrix_scanner_pkg: shared orientation codes, default glyph and rotation index helper
// Contents:
//   orient_e           ORIENT_0 / ORIENT_90 / ORIENT_180 / ORIENT_270 (clockwise)
//   DEFAULT_GLYPH_8x8  8x8 row-major glyph, row r = bits [r*8+7 : r*8], bit c = column c
//   rot_idx(o,r,c,n)   glyph bit index that feeds display pixel (r,c) under orientation o
package optotype_pkg;

    typedef enum logic [1:0] {
        ORIENT_0   = 2'd0,
        ORIENT_90  = 2'd1,
        ORIENT_180 = 2'd2,
        ORIENT_270 = 2'd3
    } orient_e;

    localparam logic [63:0] DEFAULT_GLYPH_8x8 = 64'h00003C20203C0000;

    // Source coordinates are derived by inverting the clockwise rotation of the display.
    function automatic int rot_idx(logic [1:0] o, int r, int c, int n);
        int sr;
        int sc;
        sr = (o == ORIENT_0)  ? r :
             (o == ORIENT_90) ? n - 1 - c :
             (o == ORIENT_180)? n - 1 - r : c;
        sc = (o == ORIENT_0)  ? c :
             (o == ORIENT_90) ? r :
             (o == ORIENT_180)? n - 1 - c : n - 1 - r;
        return sr * n + sc;
    endfunction

endpackage

// File: rtl/optotype_matrix_scanner_if.sv
// optotype_matrix_scanner_if: orientation/blank command channel with valid/ready handshake
// Signals:
//   cmd_valid   sender offers a command (held until accepted)
//   cmd_ready   receiver has a free pending slot
//   cmd_orient  requested orientation (orient_e encoding)
//   cmd_blank   1 = show all-off frames
// Modports: master = test-sequencing logic, slave = scanner
interface optotype_matrix_scanner_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_orient;
    logic       cmd_blank;

    modport master (output cmd_valid, output cmd_orient, output cmd_blank, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_orient, input cmd_blank, output cmd_ready);

endinterface

// File: rtl/optotype_matrix_scanner_scan_timebase.sv
// scan_timebase: row-slot prescaler and row index counter for the matrix scan
// Ports:
//   clk1        system clock
//   rst         asynchronous active-high reset
//   tick_o      last cycle of a row slot
//   r_o         current scan row index
//   boundary_o  last cycle of the last row slot (frame wrap)
//   in_blank_o  anti-ghost window at the start of each row slot
module scan_timebase #(
    parameter int N         = 8,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 4
) (
    input  logic                 clk1,
    input  logic                 rst,
    output logic                 tick_o,
    output logic [$clog2(N)-1:0] r_o,
    output logic                 boundary_o,
    output logic                 in_blank_o
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int RW = $clog2(N);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLK_END = CW'(BLANK_CYC);
    localparam logic [RW-1:0] ROW_MAX = RW'(N - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] r_q, r_d;

    assign tick_o     = (cnt_q == CNT_MAX);
    assign boundary_o = tick_o && (r_q == ROW_MAX);
    assign in_blank_o = (cnt_q < BLK_END);
    assign r_o        = r_q;

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        r_d   = !tick_o ? r_q : (r_q == ROW_MAX) ? '0 : r_q + 1'b1;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            r_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            r_q   <= r_d;
        end
    end

endmodule

// File: rtl/optotype_matrix_scanner.sv
// optotype_matrix_scanner: N x N LED matrix scanner showing a rotatable optotype glyph
// Ports:
//   clk1           system clock
//   rst            asynchronous active-high reset
//   cmd            command channel (slave): orientation/blank, applied at frame boundaries
//   auto_en_i      1 = advance orientation every AUTO_FRAMES frames
//   row_o          active-low one-hot row select, scan index r drives row_o[N-1-r]
//   col_o          active-high column data, col_o[c] = pixel (r,c)
//   frame_start_o  one-cycle pulse in the first cycle of row 0
//   cur_orient_o   orientation currently displayed
module optotype_matrix_scanner
    import optotype_pkg::*;
#(
    parameter int             N           = 8,
    parameter int             SCAN_DIV    = 1000,
    parameter int             BLANK_CYC   = 4,
    parameter int             AUTO_FRAMES = 64,
    parameter logic [N*N-1:0] GLYPH       = DEFAULT_GLYPH_8x8
) (
    input  logic                       clk1,
    input  logic                       rst,
    optotype_matrix_scanner_if.slave   cmd,
    input  logic                       auto_en_i,
    output logic [N-1:0]               row_o,
    output logic [N-1:0]               col_o,
    output logic                       frame_start_o,
    output logic [1:0]                 cur_orient_o
);

    localparam int RW = $clog2(N);
    localparam int FW = $clog2(AUTO_FRAMES + 1);
    localparam int IW = $clog2(N * N);
    localparam logic [FW-1:0] FRM_MAX = FW'(AUTO_FRAMES - 1);

    logic          tick, boundary, in_blank, frame_wrap, accept;
    logic [RW-1:0] r;
    logic [N-1:0]  pix;

    logic          pend_q, pend_d;
    logic [1:0]    pend_orient_q, pend_orient_d;
    logic          pend_blank_q, pend_blank_d;
    logic [1:0]    cur_q, cur_d;
    logic          blank_q, blank_d;
    logic [FW-1:0] frm_q, frm_d;
    logic [N-1:0]  row_q, row_d, col_q, col_d;
    logic          fs_q, fs_d;

    scan_timebase #(
        .N         (N),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timebase (
        .clk1       (clk1),
        .rst        (rst),
        .tick_o     (tick),
        .r_o        (r),
        .boundary_o (boundary),
        .in_blank_o (in_blank)
    );

    assign frame_wrap    = tick && boundary;
    assign cmd.cmd_ready = !pend_q;
    assign accept        = cmd.cmd_valid && !pend_q;
    assign row_o         = row_q;
    assign col_o         = col_q;
    assign frame_start_o = fs_q;
    assign cur_orient_o  = cur_q;

    always_comb begin
        pix = '0;
        for (int c = 0; c < N; c++)
            pix[c] = GLYPH[IW'(rot_idx(cur_q, int'(r), c, N))];
    end

    // A pending command wins over the auto step; a command accepted on the
    // wrap cycle only lands in the pending slot, so it shows one frame later.
    always_comb begin
        pend_d        = pend_q;
        pend_orient_d = pend_orient_q;
        pend_blank_d  = pend_blank_q;
        cur_d         = cur_q;
        blank_d       = blank_q;
        frm_d         = frm_q;
        if (frame_wrap && pend_q) begin
            cur_d         = pend_orient_q;
            blank_d       = pend_blank_q;
            pend_d        = 1'b0;
            pend_orient_d = '0;
            pend_blank_d  = 1'b0;
            frm_d         = '0;
        end else if (frame_wrap && auto_en_i) begin
            frm_d = (frm_q == FRM_MAX) ? '0 : frm_q + 1'b1;
            cur_d = (frm_q == FRM_MAX) ? 2'(cur_q + 2'd1) : cur_q;
        end
        if (accept) begin
            pend_d        = 1'b1;
            pend_orient_d = cmd.cmd_orient;
            pend_blank_d  = cmd.cmd_blank;
        end
        row_d = in_blank ? '1 : ~(N'(1) << (N - 1 - int'(r)));
        col_d = (in_blank || blank_q) ? '0 : pix;
        fs_d  = boundary;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            pend_q        <= 1'b0;
            pend_orient_q <= '0;
            pend_blank_q  <= 1'b0;
            cur_q         <= ORIENT_0;
            blank_q       <= 1'b0;
            frm_q         <= '0;
            row_q         <= '1;
            col_q         <= '0;
            fs_q          <= 1'b0;
        end else begin
            pend_q        <= pend_d;
            pend_orient_q <= pend_orient_d;
            pend_blank_q  <= pend_blank_d;
            cur_q         <= cur_d;
            blank_q       <= blank_d;
            frm_q         <= frm_d;
            row_q         <= row_d;
            col_q         <= col_d;
            fs_q          <= fs_d;
        end
    end

endmodule
